// File: rtl/pe_ctrl_sequencer_if.sv
// Control-stream bundle between the PE control sequencer and its user.
// The stall signal exists only when CTRL_SEQ_STALL_EN is defined.
interface pe_ctrl_sequencer_if #(
  parameter int TILE_W = 8
);
  logic              start;
  logic [TILE_W-1:0] num_tiles;
`ifdef CTRL_SEQ_STALL_EN
  logic              stall;
`endif
  logic [3:0]        ctrl_out;
  logic              busy;
  logic              done;
  logic [TILE_W-1:0] tile_idx;

  modport master (
`ifdef CTRL_SEQ_STALL_EN
    output stall,
`endif
    output start,
    output num_tiles,
    input  ctrl_out,
    input  busy,
    input  done,
    input  tile_idx
  );

  modport slave (
`ifdef CTRL_SEQ_STALL_EN
    input  stall,
`endif
    input  start,
    input  num_tiles,
    output ctrl_out,
    output busy,
    output done,
    output tile_idx
  );
endinterface

// File: rtl/pe_ctrl_sequencer.sv
// Per-cycle PE control code generator: LOAD_W / MAC / MAC_LAST per tile, FLUSH drain, done pulse.
// Optional freeze input enabled by defining CTRL_SEQ_STALL_EN.
module pe_ctrl_sequencer #(
  parameter int LOAD_CYCLES  = 4,
  parameter int MAC_CYCLES   = 16,
  parameter int DRAIN_CYCLES = 8,
  parameter int TILE_W       = 8
) (
  input logic               clk,
  input logic               rst,
  pe_ctrl_sequencer_if.slave bus
);

  localparam int MAX_AB  = (LOAD_CYCLES > MAC_CYCLES) ? LOAD_CYCLES : MAC_CYCLES;
  localparam int MAX_CYC = (MAX_AB > DRAIN_CYCLES) ? MAX_AB : DRAIN_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAC_LAST   = CNT_W'(MAC_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  localparam logic [3:0] C_NOP      = 4'd0;
  localparam logic [3:0] C_LOAD_W   = 4'd1;
  localparam logic [3:0] C_MAC      = 4'd2;
  localparam logic [3:0] C_MAC_LAST = 4'd3;
  localparam logic [3:0] C_FLUSH    = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [TILE_W-1:0] r_tile;
  logic [TILE_W-1:0] r_num;
  logic [3:0]        r_ctrl;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nx;
  logic [CNT_W-1:0]  w_cnt_nx;
  logic [TILE_W-1:0] w_tile_nx;
  logic [TILE_W-1:0] w_num_nx;
  logic [3:0]        w_ctrl_nx;
  logic              w_busy_nx;
  logic              w_done_nx;
  logic              w_stall;
  logic              w_last_tile;

`ifdef CTRL_SEQ_STALL_EN
  assign w_stall = bus.stall;
`else
  assign w_stall = 1'b0;
`endif

  // Extended by one bit so a count of 2^TILE_W-1 ends cleanly without wrap.
  assign w_last_tile = ({1'b0, r_tile} + 1'b1) >= {1'b0, r_num};

  // Code shown in the cycle where the sequencer sits at (state, count).
  function automatic logic [3:0] code_of(input state_t s, input logic [CNT_W-1:0] c);
    logic [3:0] code;
    code = C_NOP;
    case (s)
      S_LOAD:  code = C_LOAD_W;
      S_MAC:   code = (c == MAC_LAST) ? C_MAC_LAST : C_MAC;
      S_DRAIN: code = C_FLUSH;
      default: code = C_NOP;
    endcase
    return code;
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_tile_nx  = r_tile;
    w_num_nx   = r_num;
    w_ctrl_nx  = C_NOP;
    w_busy_nx  = 1'b0;
    w_done_nx  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (bus.start) begin
          w_num_nx   = bus.num_tiles;
          w_tile_nx  = '0;
          w_state_nx = (bus.num_tiles == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_cnt == LOAD_LAST) begin
          w_state_nx = S_MAC;
          w_cnt_nx   = '0;
        end
      end
      S_MAC: begin
        if (r_cnt == MAC_LAST) begin
          w_cnt_nx = '0;
          if (w_last_tile) begin
            w_state_nx = S_DRAIN;
          end else begin
            w_state_nx = S_LOAD;
            w_tile_nx  = r_tile + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_state_nx = S_DONE;
          w_cnt_nx   = '0;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase

    // A frozen sequencer keeps its position and shows NOP; the held code follows on release.
    if (w_stall && (r_state != S_IDLE)) begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_tile_nx  = r_tile;
      w_ctrl_nx  = C_NOP;
      w_busy_nx  = 1'b1;
      w_done_nx  = 1'b0;
    end else begin
      w_ctrl_nx  = code_of(w_state_nx, w_cnt_nx);
      w_busy_nx  = (w_state_nx != S_IDLE);
      w_done_nx  = (w_state_nx == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tile  <= '0;
      r_num   <= '0;
      r_ctrl  <= C_NOP;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_tile  <= w_tile_nx;
      r_num   <= w_num_nx;
      r_ctrl  <= w_ctrl_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.ctrl_out = r_ctrl;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.tile_idx = r_tile;

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Directed plus randomized bench for pe_ctrl_sequencer against a per-cycle code-list model.
module tb_pe_ctrl_sequencer;
  localparam int L  = 4;
  localparam int M  = 16;
  localparam int D  = 8;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pe_ctrl_sequencer_if #(.TILE_W(TW)) bus ();

  pe_ctrl_sequencer #(
    .LOAD_CYCLES (L),
    .MAC_CYCLES  (M),
    .DRAIN_CYCLES(D),
    .TILE_W      (TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit delay line; tap index 7 is the 8-cycle tap.
  logic [3:0] sh [8] = '{default: 4'd0};
  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) sh[i] <= sh[i-1];
    sh[0] <= bus.ctrl_out;
  end

  typedef struct {
    logic [3:0] code;
    int         tile;
    logic       busy;
    logic       done;
  } item_t;

  item_t exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected cycle list after start: codes per tile, flush, done, then idle.
  function automatic void build(input int n);
    item_t it;
    exp_q.delete();
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < L; i++) begin it = '{4'd1, t, 1'b1, 1'b0}; exp_q.push_back(it); end
      for (int i = 0; i < M - 1; i++) begin it = '{4'd2, t, 1'b1, 1'b0}; exp_q.push_back(it); end
      it = '{4'd3, t, 1'b1, 1'b0}; exp_q.push_back(it);
    end
    if (n > 0)
      for (int i = 0; i < D; i++) begin it = '{4'd4, -1, 1'b1, 1'b0}; exp_q.push_back(it); end
    it = '{4'd0, -1, 1'b1, 1'b1}; exp_q.push_back(it);
    it = '{4'd0, -1, 1'b0, 1'b0}; exp_q.push_back(it);
  endfunction

  function automatic logic pick_stall(input int cyc, input int rnd, input int from, input int len);
    return ((cyc >= from) && (cyc < from + len)) || ((rnd != 0) && ($urandom_range(0, 3) == 0));
  endfunction

  task automatic run(input int n, input int rnd, input int st_from, input int st_len,
                     input int restart_at, output int done_cyc, output int ml_cnt,
                     output int ml_cyc, output int tap_cyc, output int tap_ctrl);
    int p = 0;
    int cyc = 0;
    logic st_edge;
    logic prev_busy = 1'b0;
    bit fin = 0;
    logic [3:0] e_code;
    logic e_busy, e_done;
    int e_tile;
    build(n);
    done_cyc = -1; ml_cnt = 0; ml_cyc = -1; tap_cyc = -1; tap_ctrl = -1;
    bus.num_tiles = TW'(n);
    bus.start = 1'b1;
`ifdef CTRL_SEQ_STALL_EN
    st_edge = pick_stall(0, rnd, st_from, st_len);
    bus.stall = st_edge;
`else
    st_edge = 1'b0;
`endif
    while (!fin) begin
      step();
      cyc++;
      bus.start = (cyc == restart_at);
      if (st_edge && prev_busy) begin
        e_code = 4'd0; e_busy = 1'b1; e_done = 1'b0; e_tile = -1;
      end else begin
        e_code = exp_q[p].code; e_busy = exp_q[p].busy;
        e_done = exp_q[p].done; e_tile = exp_q[p].tile;
        p++;
        if (!e_busy) fin = 1;
      end
      check($sformatf("n%0d_c%0d_ctrl_busy_done", n, cyc),
            32'({bus.ctrl_out, bus.busy, bus.done}), 32'({e_code, e_busy, e_done}));
      if (e_tile >= 0)
        check($sformatf("n%0d_c%0d_tile", n, cyc), 32'(bus.tile_idx), 32'(e_tile));
      if (bus.done === 1'b1) done_cyc = cyc;
      if (bus.ctrl_out === 4'd3) begin ml_cnt++; ml_cyc = cyc; end
      if (sh[7] === 4'd3) begin tap_cyc = cyc; tap_ctrl = 32'(bus.ctrl_out); end
      prev_busy = e_busy;
`ifdef CTRL_SEQ_STALL_EN
      st_edge = pick_stall(cyc, rnd, st_from, st_len);
      bus.stall = st_edge;
`endif
      if (cyc > 20000) begin
        check("cycle_budget", 32'(cyc), 32'(20000));
        fin = 1;
      end
    end
    bus.start = 1'b0;
`ifdef CTRL_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
  endtask

  initial begin
    int dc, mc, mcyc, tc, tctl, n;
    bus.start = 1'b0;
    bus.num_tiles = '0;
`ifdef CTRL_SEQ_STALL_EN
    bus.stall = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) step();
    check("reset_outputs", 32'({bus.ctrl_out, bus.busy, bus.done, bus.tile_idx}), 32'(0));
    rst = 1'b0;
    step();

    // One tile; MAC_LAST must reach the 8-cycle tap during the final FLUSH.
    run(1, 0, -1, 0, 0, dc, mc, mcyc, tc, tctl);
    check("n1_done_cycle", 32'(dc), 32'(29));
    check("n1_mac_last_count", 32'(mc), 32'(1));
    check("n1_tap8_cycle", 32'(tc), 32'(mcyc + 8));
    check("n1_tap8_ctrl_is_flush", 32'(tctl), 32'(4));

    // Three tiles with an ignored start pulse during MAC of tile 0.
    run(3, 0, -1, 0, 10, dc, mc, mcyc, tc, tctl);
    check("n3_done_cycle", 32'(dc), 32'(69));
    check("n3_mac_last_count", 32'(mc), 32'(3));

    // Two tiles, then a back-to-back start in the first idle cycle.
    run(2, 0, -1, 0, 0, dc, mc, mcyc, tc, tctl);
    check("n2_done_cycle", 32'(dc), 32'(49));
    run(0, 0, -1, 0, 0, dc, mc, mcyc, tc, tctl);
    check("n0_done_cycle", 32'(dc), 32'(1));
    check("n0_no_codes", 32'(mc), 32'(0));

    // Reset wins over start.
    rst = 1'b1; bus.start = 1'b1; bus.num_tiles = TW'(5);
    step();
    check("rst_with_start", 32'({bus.ctrl_out, bus.busy, bus.done, bus.tile_idx}), 32'(0));
    rst = 1'b0; bus.start = 1'b0;
    step();
    check("rst_with_start_idle", 32'({bus.busy, bus.done}), 32'(0));

    // Reset in the middle of DRAIN.
    bus.num_tiles = TW'(1); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (23) step();
    check("mid_drain_code", 32'(bus.ctrl_out), 32'(4));
    rst = 1'b1;
    step();
    check("mid_drain_rst", 32'({bus.ctrl_out, bus.busy, bus.done, bus.tile_idx}), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_quiet", 32'({bus.ctrl_out, bus.busy, bus.done}), 32'(0));
    end

`ifdef CTRL_SEQ_STALL_EN
    run(1, 0, 8, 3, 0, dc, mc, mcyc, tc, tctl);
    check("stall3_done_cycle", 32'(dc), 32'(32));
    run(1, 0, 0, 1, 0, dc, mc, mcyc, tc, tctl);
    check("stall_idle_start_done", 32'(dc), 32'(29));
`endif

    // Largest legal tile count.
    run(255, 0, -1, 0, 0, dc, mc, mcyc, tc, tctl);
    check("n255_done_cycle", 32'(dc), 32'(255 * (L + M) + D + 1));
    check("n255_mac_last_count", 32'(mc), 32'(255));

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(0, 6);
      run(n, 1, -1, 0, 0, dc, mc, mcyc, tc, tctl);
      check($sformatf("rand%0d_mac_last_count", r), 32'(mc), 32'(n));
      repeat ($urandom_range(0, 3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
